// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start / LSB-first data / optional parity / stop, one bit per CLK.
// Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2) to every frame.
module uart_tx_ctrl #(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_LENGTH-1:0] P_DATA,
  input  logic                   Data_valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_BIT,
  output logic                   par_calc_en,
  output logic                   TX_OUT,
  output logic                   busy
);

  localparam int CW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_TWO_STOP_EN
    , STOP2
`endif
  } state_t;

  state_t                 state_reg, state_next;
  logic [DATA_LENGTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   par_en_reg, par_en_next;
  logic                   tx_reg, tx_next;
  logic                   busy_reg, busy_next;
  logic                   pce_reg, pce_next;

  // State and datapath registers; outputs are registered copies of the next-state decode.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      par_en_reg <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      pce_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      cnt_reg    <= cnt_next;
      par_en_reg <= par_en_next;
      tx_reg     <= tx_next;
      busy_reg   <= busy_next;
      pce_reg    <= pce_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = Data_valid ? START : IDLE;
      START:   state_next = DATA;
      DATA: begin
        if (cnt_reg == LAST_BIT) state_next = par_en_reg ? PARITY : STOP;
        else                     state_next = DATA;
      end
      PARITY:  state_next = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP:    state_next = STOP2;
      STOP2:   state_next = IDLE;
`else
      STOP:    state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next     = 1'b1;
    busy_next   = 1'b0;
    pce_next    = 1'b0;
    shift_next  = shift_reg;
    cnt_next    = cnt_reg;
    par_en_next = par_en_reg;

    case (state_reg)
      IDLE: begin
        if (Data_valid) begin
          shift_next  = P_DATA;
          par_en_next = PAR_EN;
        end
      end
      START:   cnt_next = '0;
      DATA: begin
        shift_next = shift_reg >> 1;
        cnt_next   = cnt_reg + 1'b1;
      end
      default: ;
    endcase

    // Entering DATA from START shows bit 0; each later DATA cycle shows the bit about to be shifted down.
    case (state_next)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
      START: begin
        tx_next   = 1'b0;
        busy_next = 1'b1;
        pce_next  = 1'b1;
      end
      DATA: begin
        tx_next   = (state_reg == START) ? shift_reg[0] : shift_reg[1];
        busy_next = 1'b1;
      end
      PARITY: begin
        tx_next   = PAR_BIT;
        busy_next = 1'b1;
      end
      STOP: begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP2: begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
      end
`endif
      default: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
    endcase
  end

  assign TX_OUT      = tx_reg;
  assign busy        = busy_reg;
  assign par_calc_en = pce_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: directed frame table, hand sequences, and randomized traffic
// checked every cycle against a queue-based frame model.
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYPE = 1'b0;
  logic       PAR_BIT = 1'b0;
  logic       par_calc_en;
  logic       TX_OUT;
  logic       busy;

  int checks = 0;
  int passes = 0;

  uart_tx_ctrl #(.DATA_LENGTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .P_DATA(P_DATA),
    .Data_valid(Data_valid),
    .PAR_EN(PAR_EN),
    .PAR_BIT(PAR_BIT),
    .par_calc_en(par_calc_en),
    .TX_OUT(TX_OUT),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: a frame is a queue of line bits built from the rules; the
  // external parity calculator is emulated by latching parity on the same accept.
  logic mq[$];
  logic m_first = 1'b0;
  always @(negedge CLK) begin
    logic p;
    if (!RST) begin
      mq.delete();
      m_first = 1'b0;
    end else if (mq.size() == 0) begin
      if (Data_valid) begin
        p = (^P_DATA) ^ PAR_TYPE;
        mq.push_back(1'b0);
        for (int i = 0; i < 8; i++) mq.push_back(P_DATA[i]);
        if (PAR_EN) mq.push_back(p);
        for (int s = 0; s < NSTOP; s++) mq.push_back(1'b1);
        PAR_BIT = p;
        m_first = 1'b1;
      end
    end else begin
      void'(mq.pop_front());
      m_first = 1'b0;
    end
    if (mq.size() != 0) begin
      chk("model_tx", TX_OUT, mq[0]);
      chk("model_busy", busy, 1'b1);
      chk("model_pce", par_calc_en, m_first);
    end else begin
      chk("model_tx", TX_OUT, 1'b1);
      chk("model_busy", busy, 1'b0);
      chk("model_pce", par_calc_en, 1'b0);
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_type;
    logic [0:11] body;      // start + data + parity bits, leftmost transmitted first
    int          body_len;
  } vec_t;

  vec_t tbl[6];

  task automatic run_frame(input int r, input bit dv_in_last_stop);
    @(negedge CLK);
    #1;
    P_DATA = tbl[r].data; PAR_EN = tbl[r].par_en; PAR_TYPE = tbl[r].par_type; Data_valid = 1'b1;
    @(negedge CLK);
    chk("start_tx", TX_OUT, tbl[r].body[0]);
    chk("start_busy", busy, 1'b1);
    chk("start_pce", par_calc_en, 1'b1);
    #1;
    Data_valid = 1'b0; P_DATA = ~tbl[r].data; PAR_EN = ~tbl[r].par_en; PAR_TYPE = ~tbl[r].par_type;
    for (int i = 1; i < tbl[r].body_len; i++) begin
      @(negedge CLK);
      chk("body_tx", TX_OUT, tbl[r].body[i]);
      chk("body_busy", busy, 1'b1);
      chk("body_pce", par_calc_en, 1'b0);
    end
    for (int s = 0; s < NSTOP; s++) begin
      @(negedge CLK);
      chk("stop_tx", TX_OUT, 1'b1);
      chk("stop_busy", busy, 1'b1);
      if (dv_in_last_stop && s == NSTOP - 1) begin
        #1;
        Data_valid = 1'b1;
      end
    end
    @(negedge CLK);
    chk("end_busy", busy, 1'b0);
    chk("end_tx", TX_OUT, 1'b1);
    #1;
    Data_valid = 1'b0;
    @(negedge CLK);
    chk("after_busy", busy, 1'b0);
    chk("after_tx", TX_OUT, 1'b1);
  endtask

  initial begin
    tbl[0] = '{data: 8'hA5, par_en: 1'b1, par_type: 1'b0, body: 12'b010100101000, body_len: 10};
    tbl[1] = '{data: 8'h0F, par_en: 1'b0, par_type: 1'b0, body: 12'b011110000000, body_len: 9};
    tbl[2] = '{data: 8'h55, par_en: 1'b1, par_type: 1'b1, body: 12'b010101010100, body_len: 10};
    tbl[3] = '{data: 8'h81, par_en: 1'b0, par_type: 1'b0, body: 12'b010000001000, body_len: 9};
    tbl[4] = '{data: 8'h00, par_en: 1'b0, par_type: 1'b0, body: 12'b000000000000, body_len: 9};
    tbl[5] = '{data: 8'hFF, par_en: 1'b1, par_type: 1'b1, body: 12'b011111111100, body_len: 10};

    // Reset held with Data_valid asserted
    Data_valid = 1'b1; P_DATA = 8'h3C;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_tx", TX_OUT, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pce", par_calc_en, 1'b0);
    end
    #1;
    RST = 1'b1; Data_valid = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_tx", TX_OUT, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end

    for (int r = 0; r < 6; r++) run_frame(r, r == 4);

    // Data_valid held across two frames; payload changes mid-frame
    @(negedge CLK);
    #1;
    P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYPE = 1'b1; Data_valid = 1'b1;
    @(negedge CLK);
    chk("hold_start", TX_OUT, tbl[2].body[0]);
    #1;
    P_DATA = 8'hFF;
    for (int i = 1; i < tbl[2].body_len; i++) begin
      @(negedge CLK);
      chk("hold_body", TX_OUT, tbl[2].body[i]);
    end
    repeat (NSTOP) begin
      @(negedge CLK);
      chk("hold_stop", TX_OUT, 1'b1);
    end
    @(negedge CLK);
    chk("hold_gap_busy", busy, 1'b0);
    chk("hold_gap_tx", TX_OUT, 1'b1);
    @(negedge CLK);
    chk("hold_next_busy", busy, 1'b1);
    chk("hold_next_tx", TX_OUT, 1'b0);
    chk("hold_next_pce", par_calc_en, 1'b1);
    #1;
    Data_valid = 1'b0;
    repeat (11 + NSTOP) @(negedge CLK);

    // Reset during the 4th data bit of 0x3C
    #1;
    P_DATA = 8'h3C; PAR_EN = 1'b1; Data_valid = 1'b1;
    @(negedge CLK);
    #1;
    Data_valid = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("midrst_tx", TX_OUT, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_pce", par_calc_en, 1'b0);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    run_frame(3, 1'b0);

    // Randomized traffic, model-checked every cycle
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      #1;
      Data_valid = ($urandom_range(0, 3) == 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYPE   = 1'($urandom);
      RST        = ($urandom_range(0, 149) != 0);
    end
    @(negedge CLK);
    #1;
    RST = 1'b1; Data_valid = 1'b0;
    repeat (15) @(negedge CLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter, clocked on the TX bit clock (one CLK = one bit time).
- Accepts a parallel byte on a Data_valid pulse and serialises it LSB-first onto TX_OUT as start / data / optional parity / stop.
- Drives the external parity calculator's output-enable (par_calc_en) and takes its PAR_BIT back.
- Sits between the system-side TX data interface and the TX pin.

Parameters:
DATA_LENGTH, 8, payload bits per frame (>=2)

Ports:
- CLK  input  1  TX bit clock.
- RST  input  1  Asynchronous active-low reset.
- P_DATA  input  DATA_LENGTH  Parallel payload; sampled on accept.
- Data_valid  input  1  Request to send P_DATA. Honoured only when busy=0.
- PAR_EN  input  1  1 = append a parity bit. Sampled on accept.
- PAR_BIT  input  1  Parity bit from the parity calculator. Must be stable from the DATA state onward.
- par_calc_en  output  1  One-cycle enable to the parity calculator's output register.
- TX_OUT  output  1  Serial line; idles high. Registered.
- busy  output  1  High while a frame is in flight. Registered.

Behaviour:
Reset (async, RST=0):
- state=IDLE, TX_OUT=1, busy=0, par_calc_en=0, bit counter=0, shift reg=0, par_en_q=0.

States: IDLE, START, DATA, PARITY, STOP. All outputs are registered and reflect the current state.

- IDLE: TX_OUT=1, busy=0.
  - Data_valid=1 at edge k: latch P_DATA into the shift reg and PAR_EN into par_en_q; go to START.
  - From edge k: TX_OUT=0, busy=1, par_calc_en=1. par_calc_en is high for exactly the START cycle.
- START: one cycle. Next state DATA; TX_OUT=shift[0]; counter=0.
- DATA: DATA_LENGTH cycles.
  - Each edge: shift right by 1, counter+1, TX_OUT=next LSB.
  - When counter==DATA_LENGTH-1: go to PARITY if par_en_q=1, else go to STOP.
- PARITY: one cycle, TX_OUT=PAR_BIT. Next state STOP.
- STOP: one cycle, TX_OUT=1.
  - Next state IDLE. busy drops to 0 on the same edge that enters IDLE.

Frame length = 1 + DATA_LENGTH + par_en_q + 1 cycles; busy is high for exactly that many cycles.

Handshake rules:
- Data_valid while busy=1 is ignored, including during the STOP cycle. No queueing.
- The earliest next accept is the first IDLE cycle, so the minimum gap between frames is one idle bit.
- P_DATA, PAR_EN and PAR_TYPE changes while busy=1 do not affect the frame in flight.
- The parity calculator latches data on Data_valid && !busy, the same edge as the accept here. With par_calc_en in START, its PAR_BIT is valid from the first DATA cycle.
- par_calc_en pulses every frame, even when PAR_EN=0. Harmless.

Reset mid-frame: immediate return to the reset values. The line goes high with no partial-frame completion.

The bit counter width is clog2(DATA_LENGTH). No illegal state is reachable; the default branch returns to IDLE with TX_OUT=1 and busy=0.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: adds a STOP2 state after STOP (TX_OUT=1, one cycle). Frame and busy length grow by 1; busy drops on entry to IDLE after STOP2.
- Undefined: single stop bit exactly as above; no STOP2 state is synthesised.

Test Plan:
- Reset then idle: RST low with Data_valid=1 -> TX_OUT=1, busy=0, par_calc_en=0. After release with no Data_valid, the line stays 1.
- P_DATA=0xA5, PAR_EN=1, external PAR_TYPE=0 (even), one-cycle Data_valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. busy is high for 11 cycles; par_calc_en is high only in the START cycle.
- P_DATA=0x0F, PAR_EN=0 -> TX_OUT 0,1,1,1,1,0,0,0,0,1. busy is high for 10 cycles; PAR_BIT is never driven on the line.
- Data_valid held high continuously with P_DATA=0x55 then 0xFF mid-frame, PAR_EN=1, PAR_TYPE=1 (odd):
  - First frame sends 0x55 with parity bit 1, unaffected by the mid-frame change.
  - The second frame starts after exactly one idle cycle and sends 0xFF.
- RST asserted during the 4th data bit of 0x3C -> TX_OUT=1 and busy=0 immediately. After release, a fresh Data_valid with 0x81 sends a clean full frame.
- UART_TX_TWO_STOP_EN defined, P_DATA=0x00, PAR_EN=0 -> 0, eight 0s, then 1,1. busy is high for 11 cycles; a Data_valid during STOP2 is ignored.
